// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even transposition sort subsystem.
package sort_pkg;

    // Default array geometry, shared with the array and its data path.
    localparam int N_DEF  = 8;
    localparam int DATA_W = 4;

    // Sequencer states; the encoding is also exported on the debug port.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SORT_EVEN = 3'd2,
        S_SORT_ODD  = 3'd3,
        S_UNLOAD    = 3'd4,
        S_DONE      = 3'd5
    } sort_state_t;

endpackage

// File: rtl/sort_sequencer.sv
// Control FSM for the odd-even transposition sort array: load N operands,
// run alternating even/odd compare-swap phases with early exit after two
// consecutive clean phases, unload N results, then pulse done.
//
// Handshakes: a transfer happens in exactly the cycle where valid and ready
// are both high (load_en / unload_en). in_ready and out_valid depend only on
// state, never on the partner's valid/ready, and either side may stall
// indefinitely.
module sort_sequencer
    import sort_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          load_en,
    output logic          even,
    output logic          odd,
    input  logic          any_swap,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          unload_en,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state_dbg
);

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sort_state_t   state;
    logic [CW-1:0] cnt;
    logic          prev_clean;
    logic          clean;

    assign clean = ~any_swap;

    // State, shared index/phase counter and previous-phase-clean flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            prev_clean <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (cnt == LAST) begin
                            state      <= S_SORT_EVEN;
                            cnt        <= '0;
                            prev_clean <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_SORT_EVEN, S_SORT_ODD: begin
                    // Early exit only once both parities have been seen clean.
                    if ((clean && prev_clean) || (cnt == LAST)) begin
                        state <= S_UNLOAD;
                        cnt   <= '0;
                    end else begin
                        state      <= (state == S_SORT_EVEN) ? S_SORT_ODD : S_SORT_EVEN;
                        cnt        <= cnt + CW'(1);
                        prev_clean <= clean;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (cnt == LAST) begin
                            state <= S_DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    prev_clean <= 1'b0;
                end
            endcase
        end
    end

    // Moore decode of the state; transfer strobes qualify with the partner.
    always_comb begin
        in_ready  = (state == S_LOAD);
        out_valid = (state == S_UNLOAD);
        even      = (state == S_SORT_EVEN);
        odd       = (state == S_SORT_ODD);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        load_en   = in_ready & in_valid;
        unload_en = out_valid & out_ready;
        state_dbg = state;
    end

endmodule

// File: doc/sort_sequencer.md
# sort_sequencer

Control FSM for the 8×4-bit odd-even transposition sort array in the sorting SoC. Sequences one complete job:
- loads N operands through a valid/ready input handshake;
- drives alternating even/odd compare-swap phases until the data is sorted or N phases have run;
- unloads N results through a valid/ready output handshake;
- signals completion.

This block carries no data. It only generates the enables that the array and the surrounding data path consume.

## Interface
Parameters:
- N, 8, number of array rows; even, ≥2
- CW, $clog2(N+1), width of the internal index/phase counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk
- start  in  1  begin a job; honoured only in IDLE
- in_valid  in  1  operand available on array input bus
- in_ready  out  1  high throughout LOAD
- load_en  out  1  in_valid & in_ready; array shifts inbus into row 0
- even  out  1  even-phase compare-swap strobe (pairs 0/1, 2/3, …)
- odd  out  1  odd-phase compare-swap strobe (pairs 1/2, …, N-3/N-2)
- any_swap  in  1  from array, combinational in the same cycle as even/odd: at least one pair out of order
- out_valid  out  1  high throughout UNLOAD
- out_ready  in  1  consumer accepts row 0 this cycle
- unload_en  out  1  out_valid & out_ready; array shifts toward row 0
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, LOAD, SORT_EVEN, SORT_ODD, UNLOAD, DONE. State is registered; all outputs are decoded from state (Moore).
- IDLE:
  - All outputs 0.
  - start=1 → LOAD, cnt←0.
- LOAD:
  - in_ready=1.
  - Each load_en increments cnt.
  - The load_en with cnt=N-1 → SORT_EVEN, cnt←0, prev_clean←0.
  - in_valid=0 stalls indefinitely.
- SORT_EVEN / SORT_ODD:
  - Exactly one of even/odd is high.
  - Each cycle is one phase; cnt counts phases.
- Phase transition rules:
  - clean = !any_swap.
  - If clean & prev_clean → UNLOAD (early exit).
  - Else if cnt=N-1 → UNLOAD.
  - Else go to the opposite phase, cnt+1, prev_clean←clean.
  - On any → UNLOAD transition, cnt←0.
- UNLOAD:
  - out_valid=1.
  - Each unload_en increments cnt.
  - The unload_en with cnt=N-1 → DONE.
  - out_ready=0 stalls indefinitely.
- DONE: done=1 for one cycle, then IDLE.
- even and odd are never both high. Both are 0 outside the SORT states.
- Array integration: the array gates its compare-swap with (even|odd), so it holds when both are low.
- start outside IDLE is ignored. It is not queued.
- reset mid-job:
  - Next state is IDLE, all outputs 0, cnt=0, prev_clean=0.
  - Array contents are not touched by this block.
- Counter never exceeds N-1. Comparisons are unsigned, CW bits.

## Timing
- Reset values: in_ready, load_en, even, odd, out_valid, unload_en, busy, done all 0.
- start high at edge k → LOAD and in_ready=1 from cycle k+1.
- Full-throughput latency, start edge to done pulse: 1 + N + P + N cycles. Here P = number of phases, 2 ≤ P ≤ N.
  - The done pulse occupies the cycle after the last unload.
  - N=8 worst case: 25 cycles.
- The minimum of 2 phases guarantees that both parities are checked before the early exit.
- Back-to-back jobs: start may be asserted during DONE but is ignored there. The earliest accepted start is the first IDLE cycle.

## Structure
- Shared package sort_pkg:
  - state enum sort_state_t;
  - default N and data width n=4, shared with the array.
- Single module.
- One CW-bit counter reused for load index, phase index and unload index.
- No sub-module is warranted.

## Test plan
- Reverse input, N=8, always ready:
  - Load 7,6,5,4,3,2,1,0 with the array model → 8 phases (E,O,E,O,…).
  - Unload yields 0..7.
  - done at cycle 25 after the start edge.
- Pre-sorted input 0..7: any_swap=0 in phases 0 and 1 → UNLOAD after exactly 2 phases; done at cycle 19.
- Early exit needs two consecutive clean phases:
  - Force any_swap pattern 1,0,1,0,0 → exit after phase 4 (5 phases).
  - even/odd never overlap.
- Handshake stalls:
  - Drop in_valid for 3 cycles after the 4th operand → LOAD holds with cnt=4 and no load_en.
  - Drop out_ready for 2 cycles mid-UNLOAD → no unload_en; 8 results are still delivered in order.
- Control edge cases:
  - start pulsed during SORT_ODD → ignored, job completes normally.
  - reset asserted during UNLOAD with cnt=3 → the next cycle is IDLE with all outputs 0.
  - A new start then runs a full job.
